interpolator_multi: RTL and testbench

//  Silencer stage for DEPTH time-multiplexed transducer channels: slew-limits intensity and phase per channel.

---
 rtl/interpolator_multi.sv | 269 ++++++++++++++++++++++++++
 tb/tb_interpolator_multi.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interpolator_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// interpolator_multi
//
// Silencer stage for DEPTH time-multiplexed transducer channels. For every
// channel the block keeps a fixed-point intensity state and a fixed-point
// phase state. On each frame it moves each state toward a new target by at
// most a programmable amount. Phase moves along the shorter way around the
// circle. An exact half turn is resolved in the positive direction.
//
// Pipeline (3 cycles from DIN_VALID to DOUT_VALID, one input per cycle):
//   S1: capture the inputs and read the channel state.
//   S2: compute the target - state difference.
//   S3: limit the step, write the state back and register the outputs.
// A channel recurs only after DEPTH >= 4 inputs. Its S3 write-back therefore
// lands before its next S1 read, so the pipeline needs no forwarding.
//
// Ports
//   CLK                    in   system clock
//   RST                    in   asynchronous, active-high reset
//   DIN_VALID              in   INTENSITY_IN/PHASE_IN valid for current channel
//   BYPASS                 in   1: state := target, output = input
//   UPDATE_RATE_INTENSITY  in   max intensity step per frame (2^-F LSB units)
//   UPDATE_RATE_PHASE      in   max phase step per frame (2^-F LSB units)
//   INTENSITY_IN           in   target intensity
//   PHASE_IN               in   target phase (full turn = 2^PHASE_WIDTH)
//   INTENSITY_OUT          out  interpolated intensity
//   PHASE_OUT              out  interpolated phase
//   DOUT_VALID             out  outputs valid, both belong to the same channel
// -----------------------------------------------------------------------------
module interpolator_multi #(
    parameter int DEPTH           = 249,
    parameter int INTENSITY_WIDTH = 16,
    parameter int PHASE_WIDTH     = 8,
    parameter int FRAC_BITS       = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       DIN_VALID,
    input  logic                       BYPASS,
    input  logic [15:0]                UPDATE_RATE_INTENSITY,
    input  logic [15:0]                UPDATE_RATE_PHASE,
    input  logic [INTENSITY_WIDTH-1:0] INTENSITY_IN,
    input  logic [PHASE_WIDTH-1:0]     PHASE_IN,
    output logic [INTENSITY_WIDTH-1:0] INTENSITY_OUT,
    output logic [PHASE_WIDTH-1:0]     PHASE_OUT,
    output logic                       DOUT_VALID
);

    localparam int IW     = INTENSITY_WIDTH;
    localparam int PW     = PHASE_WIDTH;
    localparam int F      = FRAC_BITS;
    localparam int RATE_W = 16;
    localparam int SI_W   = IW + F;           // intensity state width
    localparam int SP_W   = PW + F;           // phase state width
    localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The comparison width holds any difference magnitude and any rate without loss.
    localparam int MAX_W0 = (SI_W > SP_W) ? SI_W : SP_W;
    localparam int MAX_W1 = (MAX_W0 > RATE_W) ? MAX_W0 : RATE_W;
    localparam int MAG_W  = MAX_W1 + 1;

    localparam logic [CNT_W-1:0] LAST_CH   = CNT_W'(DEPTH - 1);
    localparam logic [SP_W-1:0]  HALF_TURN = {1'b1, {(SP_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Channel counter and per-frame rate latch
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  ch_q, ch_d;
    logic [RATE_W-1:0] rate_i_q, rate_p_q;
    logic              frame_start;
    logic [RATE_W-1:0] rate_i_eff, rate_p_eff;

    // NOTE: every output gets a default at the top of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        frame_start = DIN_VALID && (ch_q == '0);
        ch_d        = ch_q;
        if (DIN_VALID) begin
            ch_d = (ch_q == LAST_CH) ? '0 : ch_q + CNT_W'(1);
        end
        // Channel 0 uses the rate presented with it. The rest of the frame
        // uses that latched copy, so every channel in a frame sees one rate.
        rate_i_eff = frame_start ? UPDATE_RATE_INTENSITY : rate_i_q;
        rate_p_eff = frame_start ? UPDATE_RATE_PHASE     : rate_p_q;
    end

    // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values regardless of block order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ch_q     <= '0;
            rate_i_q <= '0;
            rate_p_q <= '0;
        end else begin
            ch_q <= ch_d;
            if (frame_start) begin
                rate_i_q <= UPDATE_RATE_INTENSITY;
                rate_p_q <= UPDATE_RATE_PHASE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel state storage
    // ------------------------------------------------------------------
    logic [SI_W-1:0] state_i_q [DEPTH];
    logic [SP_W-1:0] state_p_q [DEPTH];

    // ------------------------------------------------------------------
    // S1: capture inputs, read state
    // ------------------------------------------------------------------
    logic              s1_valid_q;
    logic [CNT_W-1:0]  s1_ch_q;
    logic              s1_bypass_q;
    logic [SI_W-1:0]   s1_tgt_i_q, s1_st_i_q;
    logic [SP_W-1:0]   s1_tgt_p_q, s1_st_p_q;
    logic [RATE_W-1:0] s1_rate_i_q, s1_rate_p_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_bypass_q <= 1'b0;
            s1_tgt_i_q  <= '0;
            s1_tgt_p_q  <= '0;
            s1_st_i_q   <= '0;
            s1_st_p_q   <= '0;
            s1_rate_i_q <= '0;
            s1_rate_p_q <= '0;
        end else begin
            s1_valid_q <= DIN_VALID;
            if (DIN_VALID) begin
                s1_ch_q     <= ch_q;
                s1_bypass_q <= BYPASS;
                s1_tgt_i_q  <= {INTENSITY_IN, {F{1'b0}}};
                s1_tgt_p_q  <= {PHASE_IN, {F{1'b0}}};
                s1_st_i_q   <= state_i_q[ch_q];
                s1_st_p_q   <= state_p_q[ch_q];
                s1_rate_i_q <= rate_i_eff;
                s1_rate_p_q <= rate_p_eff;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: differences
    // ------------------------------------------------------------------
    logic [SI_W:0]   diff_i_d;   // signed, one extra bit for unsigned operands
    logic [SP_W-1:0] diff_p_d;   // modular, read as signed downstream

    always_comb begin
        diff_i_d = {1'b0, s1_tgt_i_q} - {1'b0, s1_st_i_q};
        diff_p_d = s1_tgt_p_q - s1_st_p_q;
    end

    logic              s2_valid_q;
    logic [CNT_W-1:0]  s2_ch_q;
    logic              s2_bypass_q;
    logic [SI_W-1:0]   s2_tgt_i_q, s2_st_i_q;
    logic [SP_W-1:0]   s2_tgt_p_q, s2_st_p_q;
    logic [RATE_W-1:0] s2_rate_i_q, s2_rate_p_q;
    logic [SI_W:0]     s2_diff_i_q;
    logic [SP_W-1:0]   s2_diff_p_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_valid_q  <= 1'b0;
            s2_ch_q     <= '0;
            s2_bypass_q <= 1'b0;
            s2_tgt_i_q  <= '0;
            s2_tgt_p_q  <= '0;
            s2_st_i_q   <= '0;
            s2_st_p_q   <= '0;
            s2_rate_i_q <= '0;
            s2_rate_p_q <= '0;
            s2_diff_i_q <= '0;
            s2_diff_p_q <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_ch_q     <= s1_ch_q;
                s2_bypass_q <= s1_bypass_q;
                s2_tgt_i_q  <= s1_tgt_i_q;
                s2_tgt_p_q  <= s1_tgt_p_q;
                s2_st_i_q   <= s1_st_i_q;
                s2_st_p_q   <= s1_st_p_q;
                s2_rate_i_q <= s1_rate_i_q;
                s2_rate_p_q <= s1_rate_p_q;
                s2_diff_i_q <= diff_i_d;
                s2_diff_p_q <= diff_p_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: bounded step
    // ------------------------------------------------------------------
    logic signed [MAG_W-1:0] di_sext, dp_sext;
    logic [MAG_W-1:0]        mag_i, mag_p;
    logic                    neg_i, neg_p;
    logic [SI_W-1:0]         new_i_d;
    logic [SP_W-1:0]         new_p_d;

    always_comb begin
        di_sext = MAG_W'(signed'(s2_diff_i_q));
        dp_sext = MAG_W'(signed'(s2_diff_p_q));
        neg_i   = s2_diff_i_q[SI_W];
        // An exact half turn has no shorter direction, so it is treated as positive.
        neg_p   = s2_diff_p_q[SP_W-1] && (s2_diff_p_q != HALF_TURN);
        mag_i   = neg_i ? MAG_W'(-di_sext) : MAG_W'(di_sext);
        mag_p   = neg_p ? MAG_W'(-dp_sext) : MAG_W'(s2_diff_p_q);

        // The step is applied only when it is strictly smaller than |d|,
        // so truncating the rate to the state width cannot lose bits.
        if (s2_bypass_q || (mag_i <= MAG_W'(s2_rate_i_q))) begin
            new_i_d = s2_tgt_i_q;
        end else if (neg_i) begin
            new_i_d = s2_st_i_q - SI_W'(s2_rate_i_q);
        end else begin
            new_i_d = s2_st_i_q + SI_W'(s2_rate_i_q);
        end

        // Phase arithmetic wraps modulo a full turn on purpose.
        if (s2_bypass_q || (mag_p <= MAG_W'(s2_rate_p_q))) begin
            new_p_d = s2_tgt_p_q;
        end else if (neg_p) begin
            new_p_d = s2_st_p_q - SP_W'(s2_rate_p_q);
        end else begin
            new_p_d = s2_st_p_q + SP_W'(s2_rate_p_q);
        end
    end

    // NOTE: the channel state must clear on reset, so it is built from resettable flops rather than a RAM macro.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                state_i_q[k] <= '0;
                state_p_q[k] <= '0;
            end
        end else if (s2_valid_q) begin
            state_i_q[s2_ch_q] <= new_i_d;
            state_p_q[s2_ch_q] <= new_p_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs: upper bits of the new state, held between valids
    // ------------------------------------------------------------------
    logic [IW-1:0] int_out_q;
    logic [PW-1:0] ph_out_q;
    logic          dout_valid_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            int_out_q    <= '0;
            ph_out_q     <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                int_out_q <= new_i_d[SI_W-1:F];
                ph_out_q  <= new_p_d[SP_W-1:F];
            end
        end
    end

    assign INTENSITY_OUT = int_out_q;
    assign PHASE_OUT     = ph_out_q;
    assign DOUT_VALID    = dout_valid_q;

endmodule

// File: tb/tb_interpolator_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_interpolator_multi
//
// Directed bench for interpolator_multi. The design uses DEPTH = 104, which
// keeps channels 57 and 100 available while holding long ramps short.
// Each input is applied just after a rising edge. The monitor records each
// output on the falling edge into a per-channel capture array, and the bench
// tracks the channel index itself. Expected values are worked out by hand from
// the slew rules.
// -----------------------------------------------------------------------------
module tb_interpolator_multi;

    localparam int DEPTH = 104;

    logic        CLK;
    logic        RST;
    logic        DIN_VALID;
    logic        BYPASS;
    logic [15:0] UPDATE_RATE_INTENSITY;
    logic [15:0] UPDATE_RATE_PHASE;
    logic [15:0] INTENSITY_IN;
    logic [7:0]  PHASE_IN;
    logic [15:0] INTENSITY_OUT;
    logic [7:0]  PHASE_OUT;
    logic        DOUT_VALID;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] cap_i [DEPTH];
    logic [7:0]  cap_p [DEPTH];
    int          out_ch = 0;
    int          n_out  = 0;

    interpolator_multi #(
        .DEPTH(DEPTH),
        .INTENSITY_WIDTH(16),
        .PHASE_WIDTH(8),
        .FRAC_BITS(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .DIN_VALID(DIN_VALID),
        .BYPASS(BYPASS),
        .UPDATE_RATE_INTENSITY(UPDATE_RATE_INTENSITY),
        .UPDATE_RATE_PHASE(UPDATE_RATE_PHASE),
        .INTENSITY_IN(INTENSITY_IN),
        .PHASE_IN(PHASE_IN),
        .INTENSITY_OUT(INTENSITY_OUT),
        .PHASE_OUT(PHASE_OUT),
        .DOUT_VALID(DOUT_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output monitor: attributes each valid output to the next channel in sequence.
    always @(negedge CLK) begin
        if (RST) begin
            out_ch = 0;
        end else if (DOUT_VALID) begin
            cap_i[out_ch] = INTENSITY_OUT;
            cap_p[out_ch] = PHASE_OUT;
            out_ch = (out_ch == DEPTH - 1) ? 0 : out_ch + 1;
            n_out++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive only)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        DIN_VALID = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        DIN_VALID = 1'b0;
        BYPASS    = 1'b0;
        RST       = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [15:0] ti, input logic [7:0] tp,
                         input logic [15:0] ri, input logic [15:0] rp,
                         input logic byp);
        DIN_VALID             = 1'b1;
        BYPASS                = byp;
        INTENSITY_IN          = ti;
        PHASE_IN              = tp;
        UPDATE_RATE_INTENSITY = ri;
        UPDATE_RATE_PHASE     = rp;
        @(posedge CLK);
        #1;
    endtask

    // Full frame. Channels below sw get ri_lo; the rest get ri_hi. The frame ends with a drain.
    task automatic run_frame(input logic [15:0] ti, input logic [7:0] tp,
                             input logic [15:0] ri_lo, input logic [15:0] ri_hi,
                             input int sw, input logic [15:0] rp,
                             input logic byp);
        for (int k = 0; k < DEPTH; k++) begin
            drive(ti, tp, (k < sw) ? ri_lo : ri_hi, rp, byp);
        end
        idle(4);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        RST = 1'b1;
        DIN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (DOUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", DOUT_VALID);
        end
        n_checks++;
        if (INTENSITY_OUT !== 16'h0000 || PHASE_OUT !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h expected 0000/00", INTENSITY_OUT, PHASE_OUT);
        end
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        idle(5);
        n_checks++;
        if (DOUT_VALID !== 1'b0 || n_out != 0) begin
            n_fail++;
            $display("FAIL idle_no_output: got valid=%b count=%0d expected 0/0", DOUT_VALID, n_out);
        end
    endtask

    task automatic test_ramp();
        int chk[3];
        int start_out;
        int exp_v;
        chk[0] = 0;
        chk[1] = 57;
        chk[2] = DEPTH - 1;
        do_reset();
        start_out = n_out;
        for (int n = 1; n <= 300; n++) begin
            run_frame(16'h0100, 8'h00, 16'h0100, 16'h0100, DEPTH, 16'h0000, 1'b0);
            exp_v = (n < 256) ? n : 256;
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (cap_i[chk[c]] !== 16'(exp_v)) begin
                    n_fail++;
                    $display("FAIL ramp frame %0d ch %0d: got %h expected %h",
                             n, chk[c], cap_i[chk[c]], 16'(exp_v));
                end
            end
        end
        n_checks++;
        if (n_out - start_out != 300 * DEPTH) begin
            n_fail++;
            $display("FAIL ramp_output_count: got %0d expected %0d", n_out - start_out, 300 * DEPTH);
        end
        n_checks++;
        if (cap_p[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL ramp_phase_idle: got %h expected 00", cap_p[0]);
        end
    endtask

    task automatic test_phase_wrap();
        logic [7:0] exp_p;
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            // Intensity has rate 0: a far-away target must be ignored.
            run_frame(16'h5555, 8'hF0, 16'h0000, 16'h0000, DEPTH, 16'h0200, 1'b0);
            exp_p = (n >= 8) ? 8'hF0 : 8'(256 - 2 * n);
            n_checks++;
            if (cap_p[0] !== exp_p || cap_p[DEPTH-1] !== exp_p) begin
                n_fail++;
                $display("FAIL phase_wrap frame %0d: got %h/%h expected %h",
                         n, cap_p[0], cap_p[DEPTH-1], exp_p);
            end
        end
        n_checks++;
        if (cap_i[0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL rate_zero_hold: got %h expected 0000", cap_i[0]);
        end
    endtask

    task automatic test_half_turn();
        logic [7:0] exp_p;
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            run_frame(16'h0000, 8'h80, 16'h0000, 16'h0000, DEPTH, 16'h1000, 1'b0);
            exp_p = (n >= 8) ? 8'h80 : 8'(16 * n);
            n_checks++;
            if (cap_p[0] !== exp_p || cap_p[50] !== exp_p) begin
                n_fail++;
                $display("FAIL half_turn frame %0d: got %h/%h expected %h",
                         n, cap_p[0], cap_p[50], exp_p);
            end
        end
    endtask

    task automatic test_rate_change();
        do_reset();
        // Rate input rises at channel 100; this frame must still step by 1.
        run_frame(16'h1000, 8'h00, 16'h0100, 16'h0400, 100, 16'h0000, 1'b0);
        n_checks++;
        if (cap_i[0] !== 16'h0001 || cap_i[99] !== 16'h0001 ||
            cap_i[100] !== 16'h0001 || cap_i[DEPTH-1] !== 16'h0001) begin
            n_fail++;
            $display("FAIL rate_change_frame1: got %h %h %h %h expected 0001",
                     cap_i[0], cap_i[99], cap_i[100], cap_i[DEPTH-1]);
        end
        run_frame(16'h1000, 8'h00, 16'h0400, 16'h0400, DEPTH, 16'h0000, 1'b0);
        n_checks++;
        if (cap_i[0] !== 16'h0005 || cap_i[99] !== 16'h0005 ||
            cap_i[100] !== 16'h0005 || cap_i[DEPTH-1] !== 16'h0005) begin
            n_fail++;
            $display("FAIL rate_change_frame2: got %h %h %h %h expected 0005",
                     cap_i[0], cap_i[99], cap_i[100], cap_i[DEPTH-1]);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        // Channel 0 alone, to observe the exact latency. Rates are 0 and bypass still jumps.
        drive(16'h1234, 8'h56, 16'h0000, 16'h0000, 1'b1);
        DIN_VALID = 1'b0;
        n_checks++;
        if (DOUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_edge1: got %b expected 0", DOUT_VALID);
        end
        idle(1);
        n_checks++;
        if (DOUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_edge2: got %b expected 0", DOUT_VALID);
        end
        idle(1);
        n_checks++;
        if (DOUT_VALID !== 1'b1 || INTENSITY_OUT !== 16'h1234 || PHASE_OUT !== 8'h56) begin
            n_fail++;
            $display("FAIL bypass_edge3: got %b %h/%h expected 1 1234/56",
                     DOUT_VALID, INTENSITY_OUT, PHASE_OUT);
        end
        idle(1);
        n_checks++;
        if (DOUT_VALID !== 1'b0 || INTENSITY_OUT !== 16'h1234 || PHASE_OUT !== 8'h56) begin
            n_fail++;
            $display("FAIL output_hold: got %b %h/%h expected 0 1234/56",
                     DOUT_VALID, INTENSITY_OUT, PHASE_OUT);
        end
        for (int k = 1; k < DEPTH; k++) begin
            drive(16'h1234, 8'h56, 16'h0000, 16'h0000, 1'b1);
        end
        idle(4);
        n_checks++;
        if (cap_i[DEPTH-1] !== 16'h1234 || cap_p[DEPTH-1] !== 8'h56) begin
            n_fail++;
            $display("FAIL bypass_last_ch: got %h/%h expected 1234/56",
                     cap_i[DEPTH-1], cap_p[DEPTH-1]);
        end
        // Slewing resumes from the bypassed value.
        run_frame(16'h1236, 8'h56, 16'h0100, 16'h0100, DEPTH, 16'h0100, 1'b0);
        n_checks++;
        if (cap_i[0] !== 16'h1235 || cap_i[DEPTH-1] !== 16'h1235 || cap_p[0] !== 8'h56) begin
            n_fail++;
            $display("FAIL resume_step1: got %h %h/%h expected 1235/56",
                     cap_i[0], cap_i[DEPTH-1], cap_p[0]);
        end
        run_frame(16'h1236, 8'h56, 16'h0100, 16'h0100, DEPTH, 16'h0100, 1'b0);
        n_checks++;
        if (cap_i[0] !== 16'h1236 || cap_i[DEPTH-1] !== 16'h1236) begin
            n_fail++;
            $display("FAIL resume_step2: got %h %h expected 1236", cap_i[0], cap_i[DEPTH-1]);
        end
        // Downward move: 6 LSB at 4 per frame, then land exactly without overshoot.
        run_frame(16'h1230, 8'h56, 16'h0400, 16'h0400, DEPTH, 16'h0100, 1'b0);
        n_checks++;
        if (cap_i[0] !== 16'h1232) begin
            n_fail++;
            $display("FAIL down_step1: got %h expected 1232", cap_i[0]);
        end
        run_frame(16'h1230, 8'h56, 16'h0400, 16'h0400, DEPTH, 16'h0100, 1'b0);
        n_checks++;
        if (cap_i[0] !== 16'h1230 || cap_i[DEPTH-1] !== 16'h1230) begin
            n_fail++;
            $display("FAIL down_land: got %h %h expected 1230", cap_i[0], cap_i[DEPTH-1]);
        end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            run_frame(16'h0100, 8'h00, 16'h0100, 16'h0100, DEPTH, 16'h0000, 1'b0);
        end
        n_checks++;
        if (cap_i[0] !== 16'h0003) begin
            n_fail++;
            $display("FAIL pre_reset_ramp: got %h expected 0003", cap_i[0]);
        end
        for (int k = 0; k <= 57; k++) begin
            drive(16'h0100, 8'h00, 16'h0100, 16'h0000, 1'b0);
        end
        // Output now belongs to channel 55 on its fourth step.
        n_checks++;
        if (DOUT_VALID !== 1'b1 || INTENSITY_OUT !== 16'h0004) begin
            n_fail++;
            $display("FAIL pre_reset_stream: got %b %h expected 1 0004", DOUT_VALID, INTENSITY_OUT);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if (DOUT_VALID !== 1'b0 || INTENSITY_OUT !== 16'h0000 || PHASE_OUT !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got %b %h/%h expected 0 0000/00",
                     DOUT_VALID, INTENSITY_OUT, PHASE_OUT);
        end
        DIN_VALID = 1'b0;
        @(negedge CLK);
        #1;
        RST = 1'b0;
        idle(4);
        n_checks++;
        if (DOUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got %b expected 0", DOUT_VALID);
        end
        // Only the first input carries a nonzero rate. If the counter did not
        // restart at channel 0, that rate would never be latched.
        run_frame(16'h0100, 8'h00, 16'h0100, 16'h0000, 1, 16'h0000, 1'b0);
        n_checks++;
        if (cap_i[0] !== 16'h0001 || cap_i[57] !== 16'h0001 || cap_i[DEPTH-1] !== 16'h0001) begin
            n_fail++;
            $display("FAIL ramp_restart: got %h %h %h expected 0001",
                     cap_i[0], cap_i[57], cap_i[DEPTH-1]);
        end
    endtask

    // Hard bound on the run time in case the bench wedges.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST                   = 1'b1;
        DIN_VALID             = 1'b0;
        BYPASS                = 1'b0;
        UPDATE_RATE_INTENSITY = 16'h0000;
        UPDATE_RATE_PHASE     = 16'h0000;
        INTENSITY_IN          = 16'h0000;
        PHASE_IN              = 8'h00;
        test_reset();
        test_ramp();
        test_phase_wrap();
        test_half_turn();
        test_rate_change();
        test_bypass();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
